// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer releasing core reset after a debounced lock
module pll_lock_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_W        = 4
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               core_reset,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [7:0]         unlock_cnt
);

    localparam int CNT_MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sync1;
    logic               r_sync2;

    state_t             w_next_state;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [RETRY_W-1:0] w_next_retry;
    logic               w_unlock_inc;
    logic               w_locked_s;

    assign w_locked_s = r_sync2;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    // relock_req outranks every per-state decision, including timeout and loss of lock
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + CNT_W'(1);
        w_next_retry = retry_cnt;
        w_unlock_inc = 1'b0;
        if (relock_req) begin
            w_next_state = S_RESET_PLL;
            w_next_cnt   = '0;
            w_next_retry = '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == RST_LAST) begin
                        w_next_state = S_WAIT_LOCK;
                        w_next_cnt   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_next_state = S_STABLE;
                        w_next_cnt   = '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_next_cnt = '0;
                        if (retry_cnt == RETRY_LIMIT) begin
                            w_next_state = S_FAIL;
                        end else begin
                            w_next_state = S_RESET_PLL;
                            w_next_retry = retry_cnt + RETRY_W'(1);
                        end
                    end
                end
                S_STABLE: begin
                    if (!w_locked_s) begin
                        w_next_state = S_WAIT_LOCK;
                        w_next_cnt   = '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_next_state = S_RUN;
                        w_next_cnt   = '0;
                    end
                end
                S_RUN: begin
                    w_next_cnt = '0;
                    if (!w_locked_s) begin
                        w_next_state = S_WAIT_LOCK;
                        w_next_retry = '0;
                        w_unlock_inc = 1'b1;
                    end
                end
                S_FAIL: begin
                    w_next_cnt = '0;
                end
                default: begin
                    w_next_state = S_RESET_PLL;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state    <= S_RESET_PLL;
            r_cnt      <= '0;
            retry_cnt  <= '0;
            unlock_cnt <= 8'd0;
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            retry_cnt  <= w_next_retry;
            if (w_unlock_inc && (unlock_cnt != 8'hFF)) begin
                unlock_cnt <= unlock_cnt + 8'd1;
            end
            pll_rst    <= (w_next_state == S_RESET_PLL);
            core_reset <= (w_next_state != S_RUN);
            ready      <= (w_next_state == S_RUN);
            fail       <= (w_next_state == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    localparam int RST_C = 4;
    localparam int TO_C  = 20;
    localparam int ST_C  = 8;
    localparam int MAXR  = 2;
    localparam int PER   = RST_C + TO_C;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] unlock_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_C),
        .TIMEOUT_CYCLES(TO_C),
        .STABLE_CYCLES (ST_C),
        .MAX_RETRIES   (MAXR),
        .RETRY_W       (4)
    ) dut (
        .refclk    (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .core_reset(core_reset),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .unlock_cnt(unlock_cnt)
    );

    // Reference model: phase plus entry time; the lock path is a two-sample delay line
    int m_phase;
    int m_entry;
    int m_retry;
    int m_unlock;
    bit m_pipe[$];

    task automatic model_edge(input int e, input bit r, input bit rq, input bit lk);
        bit s;
        int age;
        if (r) begin
            m_phase = PH_RST; m_entry = e; m_retry = 0; m_unlock = 0;
            m_pipe = '{1'b0, 1'b0};
            return;
        end
        s = m_pipe.pop_front();
        m_pipe.push_back(lk);
        age = e - m_entry;
        if (rq) begin
            m_phase = PH_RST; m_entry = e; m_retry = 0;
        end else if (m_phase == PH_RST) begin
            if (age == RST_C) begin m_phase = PH_WAIT; m_entry = e; end
        end else if (m_phase == PH_WAIT) begin
            if (s) begin
                m_phase = PH_STABLE; m_entry = e;
            end else if (age == TO_C) begin
                m_entry = e;
                if (m_retry == MAXR) m_phase = PH_FAIL;
                else begin m_retry++; m_phase = PH_RST; end
            end
        end else if (m_phase == PH_STABLE) begin
            if (!s) begin m_phase = PH_WAIT; m_entry = e; end
            else if (age == ST_C) begin m_phase = PH_RUN; m_entry = e; end
        end else if (m_phase == PH_RUN) begin
            if (!s) begin
                m_unlock = (m_unlock < 255) ? m_unlock + 1 : 255;
                m_retry = 0; m_phase = PH_WAIT; m_entry = e;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_ready(input logic want, input int bound, output int edge_idx);
        edge_idx = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (ready === want) begin
                edge_idx = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        pll_locked = 1'b0; relock_req = 1'b0; rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({pll_rst, core_reset, ready, fail, retry_cnt, unlock_cnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: got %b%b%b%b r=%0d u=%0d, want 1100 r=0 u=0",
                     pll_rst, core_reset, ready, fail, retry_cnt, unlock_cnt);
        end
    endtask

    task automatic test_lock_sequence();
        int hi = 0;
        int n;
        int e;
        bit cr_low = 0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst) hi++;
            if (!core_reset) cr_low = 1;
            tick();
        end
        checks++;
        if (hi != RST_C) begin errors++; $display("FAIL pll_rst_pulse_len: got %0d want %0d", hi, RST_C); end
        checks++;
        if (cr_low) begin errors++; $display("FAIL core_reset_held: got released early want held"); end
        pll_locked = 1'b1;
        n = cyc + 1;
        wait_ready(1'b1, 40, e);
        checks++;
        if (e != n + 2 + ST_C) begin errors++; $display("FAIL ready_latency: got edge %0d want %0d", e, n + 2 + ST_C); end
        checks++;
        if (core_reset !== 1'b0 || retry_cnt !== 4'd0) begin
            errors++; $display("FAIL run_outputs: got core_reset=%b retry=%0d want 0 0", core_reset, retry_cnt);
        end
    endtask

    task automatic test_timeout_retry();
        int rises[$];
        int falls[$];
        int rtr[$];
        int fail_edge = -1;
        int base;
        int rel;
        bit prev;
        bit cr_ok = 1;
        bit rst_in_fail = 0;
        pll_locked = 1'b0; rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        base = cyc;
        prev = pll_rst;
        for (int i = 0; i < 90; i++) begin
            tick();
            rel = cyc - base;
            if (pll_rst && !prev) begin rises.push_back(rel); rtr.push_back(int'(retry_cnt)); end
            if (!pll_rst && prev) falls.push_back(rel);
            prev = pll_rst;
            if (fail && fail_edge < 0) fail_edge = rel;
            if (!core_reset) cr_ok = 0;
            if (fail && pll_rst) rst_in_fail = 1;
        end
        rises.push_back(-1); falls.push_back(-1); rtr.push_back(-1);
        checks++;
        if (rises.size() != 3 || rises[0] != PER || rises[1] != 2 * PER) begin
            errors++; $display("FAIL retry_pulse_starts: got n=%0d %0d %0d want %0d %0d", rises.size() - 1, rises[0], rises[1], PER, 2 * PER);
        end
        checks++;
        if (falls.size() != 4 || falls[0] != RST_C || falls[1] != PER + RST_C || falls[2] != 2 * PER + RST_C) begin
            errors++; $display("FAIL retry_pulse_ends: got n=%0d %0d %0d %0d", falls.size() - 1, falls[0], falls[1], falls[2]);
        end
        checks++;
        if (rtr[0] != 1 || rtr[1] != 2) begin errors++; $display("FAIL retry_steps: got %0d %0d want 1 2", rtr[0], rtr[1]); end
        checks++;
        if (fail_edge != 2 * PER + RST_C + TO_C) begin
            errors++; $display("FAIL fail_edge: got %0d want %0d", fail_edge, 2 * PER + RST_C + TO_C);
        end
        checks++;
        if (!cr_ok || rst_in_fail) begin errors++; $display("FAIL fail_outputs: got cr_ok=%0d prst_in_fail=%0d want 1 0", cr_ok, rst_in_fail); end
    endtask

    task automatic test_relock_from_fail();
        int hi = 1;
        int n;
        int e;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++;
        if (fail !== 1'b0 || retry_cnt !== 4'd0 || pll_rst !== 1'b1) begin
            errors++; $display("FAIL relock_clear: got fail=%b retry=%0d pll_rst=%b want 0 0 1", fail, retry_cnt, pll_rst);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pll_rst) hi++;
        end
        checks++;
        if (hi != RST_C) begin errors++; $display("FAIL relock_pulse_len: got %0d want %0d", hi, RST_C); end
        pll_locked = 1'b1;
        n = cyc + 1;
        wait_ready(1'b1, 40, e);
        checks++;
        if (e != n + 2 + ST_C) begin errors++; $display("FAIL relock_ready: got edge %0d want %0d", e, n + 2 + ST_C); end
    endtask

    task automatic test_loss_of_lock();
        int d;
        int n;
        int e;
        int cr_edge = -1;
        bit ready_at_cr = 1'b1;
        bit saw_prst = 0;
        pll_locked = 1'b0;
        d = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (core_reset && cr_edge < 0) begin cr_edge = cyc; ready_at_cr = ready; end
            if (pll_rst) saw_prst = 1;
        end
        pll_locked = 1'b1;
        n = cyc + 1;
        wait_ready(1'b1, 40, e);
        if (pll_rst) saw_prst = 1;
        checks++;
        if (cr_edge != d + 2 || ready_at_cr !== 1'b0) begin
            errors++; $display("FAIL unlock_latency: got edge %0d ready=%b want %0d 0", cr_edge, ready_at_cr, d + 2);
        end
        checks++;
        if (unlock_cnt !== 8'd1) begin errors++; $display("FAIL unlock_count: got %0d want 1", unlock_cnt); end
        checks++;
        if (e != n + 2 + ST_C || saw_prst) begin
            errors++; $display("FAIL unlock_recover: got edge %0d prst=%0d want %0d 0", e, saw_prst, n + 2 + ST_C);
        end
    endtask

    task automatic test_stable_glitch();
        bit seen = 0;
        pll_locked = 1'b0; rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        for (int i = 0; i < 15; i++) begin tick(); if (ready) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL stable_abort: got ready=1 want 0"); end
        pll_locked = 1'b1;
        tick();
        pll_locked = 1'b0;
        for (int i = 0; i < 15; i++) begin tick(); if (ready) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL glitch_filtered: got ready=1 want 0"); end
    endtask

    task automatic cycle_unlocks(input int count, output int misses);
        int e;
        misses = 0;
        for (int k = 0; k < count; k++) begin
            pll_locked = 1'b1;
            wait_ready(1'b1, 40, e);
            if (e < 0) misses++;
            pll_locked = 1'b0;
            wait_ready(1'b0, 10, e);
            if (e < 0) misses++;
        end
    endtask

    task automatic relock_with_drop(input int want_unlock, input string tag);
        int e;
        pll_locked = 1'b1;
        wait_ready(1'b1, 40, e);
        pll_locked = 1'b0;
        tick();
        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++;
        if (e < 0 || pll_rst !== 1'b1 || ready !== 1'b0 || unlock_cnt !== 8'(want_unlock)) begin
            errors++; $display("FAIL %s: got rdy_edge=%0d pll_rst=%b ready=%b unlock=%0d want pll_rst=1 ready=0 unlock=%0d",
                               tag, e, pll_rst, ready, unlock_cnt, want_unlock);
        end
    endtask

    task automatic test_unlock_saturation();
        int misses;
        int total = 0;
        pll_locked = 1'b0; rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        cycle_unlocks(10, misses);
        total += misses;
        checks++;
        if (unlock_cnt !== 8'd10) begin errors++; $display("FAIL unlock_ten: got %0d want 10", unlock_cnt); end
        relock_with_drop(10, "relock_beats_drop");
        cycle_unlocks(250, misses);
        total += misses;
        checks++;
        if (unlock_cnt !== 8'd255 || total != 0) begin
            errors++; $display("FAIL unlock_saturate: got %0d misses=%0d want 255 0", unlock_cnt, total);
        end
        relock_with_drop(255, "relock_at_saturation");
    endtask

    task automatic test_random();
        bit r;
        bit rq;
        bit lk = 0;
        int hold = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = (i < 2) || ($urandom_range(0, 1499) == 0);
            rq = ($urandom_range(0, 149) == 0);
            if (hold == 0) begin
                lk = ~lk;
                hold = lk ? $urandom_range(1, 40) : $urandom_range(1, 30);
            end
            hold--;
            rst = r; relock_req = rq; pll_locked = lk;
            tick();
            model_edge(cyc, r, rq, lk);
            checks++;
            if ({pll_rst, core_reset, ready, fail, retry_cnt, unlock_cnt} !==
                {m_phase == PH_RST, m_phase != PH_RUN, m_phase == PH_RUN, m_phase == PH_FAIL, 4'(m_retry), 8'(m_unlock)}) begin
                errors++;
                $display("FAIL random_model @%0d: got prst=%b cr=%b rdy=%b fail=%b r=%0d u=%0d want phase=%0d r=%0d u=%0d",
                         cyc, pll_rst, core_reset, ready, fail, retry_cnt, unlock_cnt, m_phase, m_retry, m_unlock);
            end
            checks++;
            if ((ready && core_reset) || (pll_rst && ready) || (fail && !core_reset)) begin
                errors++;
                $display("FAIL random_invariant @%0d: got prst=%b cr=%b rdy=%b fail=%b", cyc, pll_rst, core_reset, ready, fail);
            end
        end
        rst = 1'b0; relock_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_timeout_retry();
        test_relock_from_fail();
        test_loss_of_lock();
        test_stable_glitch();
        test_unlock_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the reset side of a core PLL. It drives the PLL reset, watches the asynchronous PLL lock output, debounces it, and releases a clean core reset only after a stable lock.
- Recovers from lock timeouts with bounded retries. Detects loss of lock while running and re-holds the core in reset.
- Sits between the PLL wrapper and the core logic, on the free-running reference clock.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per PLL reset pulse (>=1).
- TIMEOUT_CYCLES, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (>=1).
- MAX_RETRIES, 3: retries before declaring failure.
- RETRY_W, 4: width of retry_cnt; must hold MAX_RETRIES.

Ports:
- refclk, in, 1: reference clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- pll_locked, in, 1: PLL lock, asynchronous to refclk.
- relock_req, in, 1: single-cycle request to restart the PLL sequence.
- pll_rst, out, 1: reset to the PLL.
- core_reset, out, 1: reset to core logic, active high.
- ready, out, 1: core released, PLL locked.
- fail, out, 1: retries exhausted.
- retry_cnt, out, RETRY_W: retries in the current acquisition.
- unlock_cnt, out, 8: loss-of-lock events seen in RUN, saturating at 255.

Behaviour:
- Synchronizer: pll_locked passes through a 2-FF synchronizer to give locked_s. Both FFs reset to 0. Only locked_s is used internally.
- All outputs are registered and decoded from the state register. On rst: state = RESET_PLL, cnt = 0, pll_rst = 1, core_reset = 1, ready = 0, fail = 0, retry_cnt = 0, unlock_cnt = 0.
- RESET_PLL:
  - pll_rst = 1, core_reset = 1.
  - cnt counts 0..RST_CYCLES-1. At RST_CYCLES-1, go to WAIT_LOCK with cnt = 0.
- WAIT_LOCK:
  - pll_rst = 0, core_reset = 1.
  - locked_s = 1: go to STABLE, cnt = 0.
  - Otherwise cnt increments. At cnt == TIMEOUT_CYCLES-1:
    - if retry_cnt == MAX_RETRIES, go to FAIL;
    - else retry_cnt += 1 and go to RESET_PLL with cnt = 0.
- STABLE:
  - core_reset = 1.
  - locked_s = 0: return to WAIT_LOCK with cnt = 0. The timeout restarts; retry_cnt is unchanged.
  - At cnt == STABLE_CYCLES-1 with locked_s = 1: go to RUN.
- RUN:
  - core_reset = 0, ready = 1.
  - locked_s = 0: go to WAIT_LOCK with cnt = 0, retry_cnt = 0, unlock_cnt saturating-increments. core_reset = 1 and ready = 0 from the next edge.
- FAIL:
  - fail = 1, pll_rst = 0, core_reset = 1, ready = 0.
  - Stays in FAIL until relock_req or rst.
- relock_req, in any state:
  - Highest priority; it overrides loss of lock and timeout in the same cycle.
  - Go to RESET_PLL with cnt = 0, retry_cnt = 0, fail = 0.
  - unlock_cnt is not incremented on that cycle.
  - In RESET_PLL it restarts the pulse, so the pulse is stretched.
- Latency: if edge N is the first to sample pll_locked = 1 (in WAIT_LOCK, held high), then STABLE is entered at edge N+2 and ready rises at edge N+2+STABLE_CYCLES.
- Loss-of-lock latency: core_reset rises 3 edges after pll_locked falls (2 synchronizer edges + 1 state edge).
- Invariants:
  - ready = 1 implies core_reset = 0.
  - pll_rst and ready are never high together.
  - fail = 1 implies core_reset = 1.
  - unlock_cnt holds at 255.
- rst mid-operation: all outputs reach their reset values on the next edge, independent of state.

Test Plan:
All scenarios use RST_CYCLES=4, TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Hold rst for 3 cycles, then raise pll_locked 10 cycles after rst drops -> pll_rst high for exactly 4 cycles. ready rises at edge N+10 (N = first edge sampling pll_locked = 1). core_reset falls on the same edge. retry_cnt = 0.
2. Keep pll_locked = 0 -> pll_rst pulses of 4 cycles, 24 cycles apart. retry_cnt steps 1, 2. fail rises 20 cycles after the third pulse. core_reset stays 1. pll_rst stays 0 while in FAIL.
3. In FAIL, pulse relock_req, then assert pll_locked -> fail clears next edge, retry_cnt = 0, a new 4-cycle pll_rst pulse, then ready per scenario 1 timing.
4. In RUN, drop pll_locked for 5 cycles, then restore -> core_reset rises 3 edges after the drop. unlock_cnt = 1. ready returns 10 edges after the first edge sampling pll_locked = 1 again. No pll_rst pulse.
5. Toggle pll_locked high for 5 cycles then low during STABLE -> state returns to WAIT_LOCK and ready never asserts. A 1-cycle glitch is filtered or counted per the synchronizer model.
6. Cause 260 unlock events in RUN -> unlock_cnt saturates at 255. Assert relock_req and a lock drop on the same cycle -> RESET_PLL is entered and unlock_cnt is unchanged.
